// File: rtl/onehot_encoder_pipe.sv
// -----------------------------------------------------------------------------
// onehot_encoder_pipe
//
// Two-stage pipelined one-hot to binary encoder with valid/ready handshakes
// on both sides. Stage 1 registers the incoming vector. Stage 2 registers
// the lowest-set-bit index and the zero-hot and multi-hot flags. A
// saturating counter tracks how many erroneous beats have been delivered
// downstream.
//
// Parameters:
//   INPUT_W   : one-hot vector width (>= 2)
//   OUTPUT_W  : binary index width, defaults to $clog2(INPUT_W)
//   ERR_CNT_W : error counter width
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i_data      : one-hot input vector
//   i_valid     : i_data is valid
//   i_ready     : block accepts i_data this cycle
//   o_data      : binary index of the lowest set bit (0 for a zero-hot beat)
//   o_err_zero  : delivered beat had no bit set
//   o_err_multi : delivered beat had two or more bits set
//   o_valid     : o_data and flags are valid
//   o_ready     : downstream accepts this cycle
//   err_clr     : synchronous clear of err_cnt (wins over an increment)
//   err_cnt     : saturating count of erroneous beats delivered
// -----------------------------------------------------------------------------
module onehot_encoder_pipe #(
   parameter int unsigned INPUT_W   = 8,
   parameter int unsigned OUTPUT_W  = $clog2(INPUT_W),
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [INPUT_W-1:0]   i_data,
   input  logic                 i_valid,
   output logic                 i_ready,
   output logic [OUTPUT_W-1:0]  o_data,
   output logic                 o_err_zero,
   output logic                 o_err_multi,
   output logic                 o_valid,
   input  logic                 o_ready,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [INPUT_W-1:0]   IN_ONE  = INPUT_W'(1);
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   // Stage 1: raw vector
   logic [INPUT_W-1:0]   r_s1_data;
   logic                 r_s1_valid;

   // Stage 2: encoded index and flags
   logic [OUTPUT_W-1:0]  r_s2_data;
   logic                 r_s2_zero;
   logic                 r_s2_multi;
   logic                 r_s2_valid;

   logic [ERR_CNT_W-1:0] r_err_cnt;

   logic                 w_s1_ready;
   logic                 w_s2_ready;
   logic [OUTPUT_W-1:0]  w_idx;
   logic                 w_zero;
   logic                 w_multi;
   logic                 w_out_hs;
   logic                 w_err_beat;

   // ---------------------------------------------------------------------
   // Ready chain: combinational from o_ready back to i_ready, so a full
   // pipeline can accept a new beat in the same cycle it drains one.
   // ---------------------------------------------------------------------
   assign w_s2_ready = !r_s2_valid || o_ready;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;
   assign i_ready    = w_s1_ready;

   // ---------------------------------------------------------------------
   // Encoder: scanning from the top down lets the lowest set bit win.
   // ---------------------------------------------------------------------
   always_comb begin
      w_idx = '0;
      for (int unsigned i = INPUT_W; i > 0; i--) begin
         if (r_s1_data[i-1]) begin
            w_idx = OUTPUT_W'(i - 1);
         end
      end
   end

   assign w_zero  = (r_s1_data == '0);
   // Clearing the lowest set bit leaves something only if 2+ bits were set.
   assign w_multi = ((r_s1_data & (r_s1_data - IN_ONE)) != '0);

   // ---------------------------------------------------------------------
   // Stage 1 register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else if (w_s1_ready) begin
         r_s1_valid <= i_valid;
         if (i_valid) begin
            r_s1_data <= i_data;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_zero  <= 1'b0;
         r_s2_multi <= 1'b0;
      end else if (w_s2_ready) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data  <= w_idx;
            r_s2_zero  <= w_zero;
            r_s2_multi <= w_multi;
         end
      end
   end

   assign o_data      = r_s2_data;
   assign o_err_zero  = r_s2_zero;
   assign o_err_multi = r_s2_multi;
   assign o_valid     = r_s2_valid;

   // ---------------------------------------------------------------------
   // Error counter: counts delivered (handshaken) erroneous beats only.
   // ---------------------------------------------------------------------
   assign w_out_hs   = r_s2_valid && o_ready;
   assign w_err_beat = w_out_hs && (r_s2_zero || r_s2_multi);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= '0;
      end else if (err_clr) begin
         r_err_cnt <= '0;
      end else if (w_err_beat && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + CNT_ONE;
      end
   end

   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_onehot_encoder_pipe
//
// Scoreboard bench for onehot_encoder_pipe (INPUT_W=8, ERR_CNT_W=2).
// The driver pushes the expected encoding of every accepted beat; a monitor
// on the falling edge compares whatever the DUT presents against the head
// of the queue and tracks the expected error count.
// -----------------------------------------------------------------------------
module tb_onehot_encoder_pipe;

   localparam int unsigned IW   = 8;
   localparam int unsigned OW   = 3;
   localparam int unsigned CW   = 2;
   localparam int unsigned CMAX = 3;

   logic          clk;
   logic          rst_n;
   logic [IW-1:0] i_data;
   logic          i_valid;
   logic          i_ready;
   logic [OW-1:0] o_data;
   logic          o_err_zero;
   logic          o_err_multi;
   logic          o_valid;
   logic          o_ready;
   logic          err_clr;
   logic [CW-1:0] err_cnt;

   onehot_encoder_pipe #(
      .INPUT_W   (IW),
      .ERR_CNT_W (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_err_zero  (o_err_zero),
      .o_err_multi (o_err_multi),
      .o_valid     (o_valid),
      .o_ready     (o_ready),
      .err_clr     (err_clr),
      .err_cnt     (err_cnt)
   );

   typedef struct {
      logic [OW-1:0] idx;
      logic          zero;
      logic          multi;
   } exp_t;

   exp_t        sb[$];
   int          hs_cyc[$];
   int          tests   = 0;
   int          fails   = 0;
   int          cyc     = 0;
   int unsigned exp_cnt = 0;
   bit          rnd_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Reference: index = number of trailing zeros, flags from the bit count.
   function automatic exp_t model(input logic [IW-1:0] d);
      exp_t          e;
      logic [IW-1:0] t;
      int            n;
      t = d;
      n = 0;
      if (d != '0) begin
         while (t[0] == 1'b0) begin
            t = t >> 1;
            n++;
         end
      end
      e.idx   = OW'(n);
      e.zero  = (d == '0);
      e.multi = ($countones(d) > 1);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and wait (bounded) for the handshake.
   task automatic send(input logic [IW-1:0] d, output int waits);
      i_data  = d;
      i_valid = 1'b1;
      waits   = 0;
      forever begin
         @(negedge clk);
         if (i_ready) begin
            sb.push_back(model(d));
            break;
         end
         waits++;
         if (waits > 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got i_ready=0 expected 1 within 200 cycles");
            break;
         end
      end
      step();
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      o_ready = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
      step();
   endtask

   // Monitor: compare presented beats against the scoreboard head (every
   // cycle, so a stalled output must hold), pop on handshake, model err_cnt.
   always @(negedge clk) begin
      exp_t        e;
      int unsigned nxt;
      if (!rst_n) begin
         exp_cnt = 0;
      end else begin
         chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
         nxt = exp_cnt;
         if (o_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got o_data=%0d with empty scoreboard", o_data);
            end else begin
               e = sb[0];
               chk("o_data",      32'(o_data),      32'(e.idx));
               chk("o_err_zero",  32'(o_err_zero),  32'(e.zero));
               chk("o_err_multi", 32'(o_err_multi), 32'(e.multi));
               if (o_ready) begin
                  void'(sb.pop_front());
                  hs_cyc.push_back(cyc);
                  if ((e.zero || e.multi) && nxt < CMAX) nxt++;
               end
            end
         end
         if (err_clr) nxt = 0;
         exp_cnt = nxt;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      o_ready = 1'b0;
      err_clr = 1'b0;
      rnd_done = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_i_ready", 32'(i_ready), 32'd1);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_o_data",  32'(o_data),  32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Single beat, two-cycle latency
      o_ready = 1'b1;
      send(8'b0010_0000, w);
      chk("single_wait", 32'(w), 32'd0);
      @(negedge clk);
      chk("lat_not_yet", 32'(o_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(o_valid), 32'd1);
      chk("lat_data",  32'(o_data),  32'd5);
      drain();

      // Streaming all one-hot values back to back
      hs_cyc.delete();
      for (int i = 0; i < 8; i++) send(IW'(1 << i), w);
      drain();
      chk("stream_count", 32'(hs_cyc.size()), 32'd8);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("stream_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd1);
      chk("stream_err_cnt", 32'(err_cnt), 32'd0);

      // Zero-hot and multi-hot beats
      send(8'h00, w);
      send(8'b1001_0100, w);
      drain();
      @(negedge clk);
      chk("errs_cnt2", 32'(err_cnt), 32'd2);
      step();

      // Backpressure: two beats fill the pipe, third waits upstream
      o_ready = 1'b0;
      hs_cyc.delete();
      send(8'h01, w);
      chk("bp_wait1", 32'(w), 32'd0);
      send(8'h02, w);
      chk("bp_wait2", 32'(w), 32'd0);
      i_data  = 8'h04;
      i_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_i_ready_low", 32'(i_ready), 32'd0);
         chk("bp_hold_valid",  32'(o_valid), 32'd1);
         chk("bp_hold_data",   32'(o_data),  32'd0);
      end
      step();
      o_ready = 1'b1;
      send(8'h04, w);
      chk("bp_release_comb", 32'(w), 32'd0);
      drain();
      chk("bp_count", 32'(hs_cyc.size()), 32'd3);
      for (int i = 1; i < hs_cyc.size(); i++)
         chk("bp_gap", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd1);

      // Saturation, then clear colliding with an erroneous handshake
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      for (int i = 0; i < 5; i++) send(8'h00, w);
      drain();
      @(negedge clk);
      chk("sat_cnt", 32'(err_cnt), 32'(CMAX));
      step();
      o_ready = 1'b0;
      send(8'h00, w);
      n = 0;
      while (!o_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("clr_beat_ready", 32'(o_valid), 32'd1);
      step();
      o_ready = 1'b1;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge clk);
      chk("clr_wins", 32'(err_cnt), 32'd0);
      chk("clr_sb_empty", 32'(sb.size()), 32'd0);
      step();

      // Reset with two beats in flight
      o_ready = 1'b0;
      send(8'h01, w);
      send(8'h02, w);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_o_valid", 32'(o_valid), 32'd0);
      chk("midrst_i_ready", 32'(i_ready), 32'd1);
      sb.delete();
      step();
      step();
      rst_n   = 1'b1;
      o_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("midrst_no_stale", 32'(o_valid), 32'd0);
      end
      step();

      // Randomized traffic with random backpressure and clears
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int unsigned r;
               logic [IW-1:0] d;
               r = $urandom_range(0, 9);
               if (r < 7)       d = IW'(1 << $urandom_range(0, IW - 1));
               else if (r == 7) d = '0;
               else             d = IW'($urandom);
               send(d, w);
               repeat ($urandom_range(0, 1)) step();
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               step();
               o_ready = ($urandom_range(0, 3) != 0);
               err_clr = ($urandom_range(0, 15) == 0);
            end
         end
      join
      err_clr = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
